// File: rtl/ram_loader_if.sv
// Byte-stream input and memory write port of ram_loader, bundled as one interface.
// slave is the loader side; master is the byte source / memory side.
interface ram_loader_if #(
   parameter int WIDTH = 8,
   parameter int ADDRW = 8
);
   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_ready;
   logic             we;
   logic [ADDRW-1:0] waddr;
   logic [WIDTH-1:0] wdata;

   modport slave (
      input  s_data, s_valid,
      output s_ready, we, waddr, wdata
   );

   modport master (
      output s_data, s_valid,
      input  s_ready, we, waddr, wdata
   );
endinterface

// File: rtl/ram_loader.sv
// Packs a little-endian byte stream into WIDTH-bit words and writes them to a RAM
// at consecutive addresses from 0; len words per load, clamped to DEPTH.
module ram_loader #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADDRW:0]   len,
   input  logic             abort,
   ram_loader_if.slave      ifc,
   output logic             busy,
   output logic             done
);
   localparam int BYTES = WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [ADDRW:0] DEPTH_W   = (ADDRW + 1)'(DEPTH);
   localparam logic [BCW-1:0] LAST_LANE = BCW'(BYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t           state, state_n;
   logic [ADDRW:0]   len_q, len_n;
   logic [ADDRW:0]   word_cnt, word_n;
   logic [BCW-1:0]   byte_cnt, byte_n;
   logic [WIDTH-1:0] asm_q, asm_n, word_nx;
   logic             s_ready_q, busy_q, done_q, we_q, we_n;
   logic [ADDRW-1:0] waddr_q, waddr_n;
   logic [WIDTH-1:0] wdata_q, wdata_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         word_cnt  <= '0;
         byte_cnt  <= '0;
         asm_q     <= '0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state     <= state_n;
         len_q     <= len_n;
         word_cnt  <= word_n;
         byte_cnt  <= byte_n;
         asm_q     <= asm_n;
         s_ready_q <= (state_n == LOAD);
         busy_q    <= (state_n == LOAD);
         done_q    <= (state_n == DONE);
         we_q      <= we_n;
         waddr_q   <= waddr_n;
         wdata_q   <= wdata_n;
      end
   end

   // Word with the incoming byte dropped into its lane; used for both the
   // partial accumulator and the completed write.
   always_comb begin
      word_nx = asm_q;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (byte_cnt == BCW'(i)) word_nx[8*i +: 8] = ifc.s_data;
      end
   end

   always_comb begin
      state_n = state;
      len_n   = len_q;
      word_n  = word_cnt;
      byte_n  = byte_cnt;
      asm_n   = asm_q;
      we_n    = 1'b0;
      waddr_n = waddr_q;
      wdata_n = wdata_q;

      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_n = LOAD;
                  len_n   = (len > DEPTH_W) ? DEPTH_W : len;
                  word_n  = '0;
                  byte_n  = '0;
                  asm_n   = '0;
               end else begin
                  state_n = DONE;
               end
            end
         end
         LOAD: begin
            if (s_ready_q && ifc.s_valid) begin
               asm_n = word_nx;
               if (byte_cnt == LAST_LANE) begin
                  we_n    = 1'b1;
                  waddr_n = word_cnt[ADDRW-1:0];
                  wdata_n = word_nx;
                  word_n  = word_cnt + 1'b1;
                  byte_n  = '0;
                  if (word_cnt + 1'b1 == len_q) state_n = DONE;
               end else begin
                  byte_n = byte_cnt + 1'b1;
               end
            end
            // Abort overrides the exit to DONE but keeps a write already formed this cycle.
            if (abort) state_n = IDLE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign ifc.s_ready = s_ready_q;
   assign ifc.we      = we_q;
   assign ifc.waddr   = waddr_q;
   assign ifc.wdata   = wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed and randomized checks of ram_loader (WIDTH=16, DEPTH=4) against a
// word-list reference model built from the bytes actually offered.
module tb_ram_loader;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int ADDRW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [ADDRW:0]   len = '0;
   logic             busy, done;

   ram_loader_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) bus ();

   ram_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .len   (len),
      .abort (abort),
      .ifc   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write/done log, sampled mid-cycle.
   int               wr_t[$];
   logic [ADDRW-1:0] wr_a[$];
   logic [WIDTH-1:0] wr_d[$];
   int               done_t[$];

   always @(negedge clk) begin
      if (bus.we) begin
         wr_t.push_back(cyc);
         wr_a.push_back(bus.waddr);
         wr_d.push_back(bus.wdata);
      end
      if (done) done_t.push_back(cyc);
   end

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]       tx[$];
   logic [7:0]       allb[$];
   logic [WIDTH-1:0] exp_w[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: word i = little-endian pack of bytes 2i, 2i+1, for min(n, DEPTH) words.
   function automatic void build_expect(input int n);
      int nw;
      exp_w.delete();
      nw = (n < DEPTH) ? n : DEPTH;
      for (int i = 0; i < nw; i++) exp_w.push_back({tx[2*i+1], tx[2*i]});
   endfunction

   task automatic clear_log();
      wr_t.delete(); wr_a.delete(); wr_d.delete(); done_t.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input logic [ADDRW:0] l, output int ts);
      @(negedge clk);
      start = 1'b1; len = l; ts = cyc;
      @(negedge clk);
      start = 1'b0;
      if (l != 0) begin
         chk("ready_after_start", bus.s_ready, 1);
         chk("busy_after_start", busy, 1);
      end else begin
         chk("done_after_zero_start", done, 1);
      end
   endtask

   // mode 0: valid held high; 1: valid pattern 1,0,0,1; 2: random valid.
   task automatic send(input int mode, input bit abort_last, output int last_acc);
      int g;
      int timed_out;
      logic v, rdy;
      g = 0; timed_out = 0; last_acc = 0;
      for (int k = 0; k < tx.size(); k++) begin
         bit accepted;
         int budget;
         accepted = 0; budget = 0;
         while (!accepted && budget < 50) begin
            @(negedge clk);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 4 == 0) || (g % 4 == 3)) : 1'($urandom_range(0, 1));
            g++;
            rdy = bus.s_ready;
            bus.s_valid = v;
            bus.s_data  = tx[k];
            abort = abort_last && (k == tx.size() - 1) && v && rdy;
            if (v && rdy) begin accepted = 1; last_acc = cyc; end
            budget++;
         end
         if (!accepted) timed_out = 1;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      abort = 1'b0;
      chk("send_timeout", timed_out, 0);
   endtask

   task automatic check_load(input string name, input bit exp_done, input int last_acc);
      int n;
      chk({name, "_nwrites"}, wr_d.size(), exp_w.size());
      n = (wr_d.size() < exp_w.size()) ? wr_d.size() : exp_w.size();
      for (int i = 0; i < n; i++) begin
         chk({name, "_waddr"}, wr_a[i], i);
         chk({name, "_wdata"}, wr_d[i], exp_w[i]);
      end
      chk({name, "_ndone"}, done_t.size(), exp_done);
      if (exp_done && done_t.size() > 0) begin
         chk({name, "_done_time"}, done_t[0], last_acc + 1);
         if (exp_w.size() > 0 && wr_t.size() > 0)
            chk({name, "_last_we_time"}, wr_t[wr_t.size()-1], last_acc + 1);
      end
      chk({name, "_busy_idle"}, busy, 0);
      chk({name, "_ready_idle"}, bus.s_ready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ts, la, l, nb;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #2;
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_waddr", bus.waddr, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Basic load, valid held high
      tx.delete();
      for (int k = 0; k < 8; k++) tx.push_back(8'(k + 1));
      do_start(4, ts);
      send(0, 0, la);
      idle(3);
      build_expect(4);
      chk("basic_word0", exp_w[0], 16'h0201);
      check_load("basic", 1, la);
      for (int i = 1; i < wr_t.size(); i++) chk("basic_spacing", wr_t[i] - wr_t[i-1], 2);
      clear_log();

      // Backpressure gaps
      do_start(4, ts);
      send(1, 0, la);
      idle(3);
      check_load("gaps", 1, la);
      clear_log();

      // Zero length
      do_start(0, ts);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         chk("zero_ready_low", bus.s_ready, 0);
      end
      bus.s_valid = 1'b0;
      idle(2);
      tx.delete();
      build_expect(0);
      check_load("zero", 1, ts);
      clear_log();

      // Clamped length: 7 requested, DEPTH words written
      tx.delete();
      for (int k = 0; k < 8; k++) tx.push_back(8'($urandom));
      do_start(7, ts);
      send(0, 0, la);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         chk("clamp_ready_low", bus.s_ready, 0);
      end
      bus.s_valid = 1'b0;
      idle(2);
      build_expect(7);
      check_load("clamp", 1, la);
      clear_log();

      // Abort after 3 bytes
      tx.delete();
      for (int k = 0; k < 3; k++) tx.push_back(8'(k + 1));
      do_start(4, ts);
      send(0, 0, la);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy_next", busy, 0);
      idle(3);
      build_expect(1);
      check_load("abort", 0, la);
      clear_log();

      // Reload after abort starts at address 0
      tx.delete();
      for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
      do_start(2, ts);
      send(2, 0, la);
      idle(3);
      build_expect(2);
      check_load("reload", 1, la);
      clear_log();

      // Abort in the same cycle as a word-completing byte keeps that write
      tx.delete();
      for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
      do_start(4, ts);
      send(0, 1, la);
      idle(3);
      build_expect(2);
      check_load("abort_same", 0, la);
      clear_log();

      // Reset mid-load, between edges
      tx.delete();
      for (int k = 0; k < 5; k++) tx.push_back(8'($urandom));
      do_start(4, ts);
      send(0, 0, la);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_s_ready", bus.s_ready, 0);
      chk("midrst_we", bus.we, 0);
      chk("midrst_waddr", bus.waddr, 0);
      chk("midrst_wdata", bus.wdata, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      idle(2);
      rst_n = 1'b1;
      clear_log();
      tx.delete();
      for (int k = 0; k < 4; k++) tx.push_back(8'($urandom));
      do_start(2, ts);
      send(0, 0, la);
      idle(3);
      build_expect(2);
      check_load("after_rst", 1, la);
      clear_log();

      // start during LOAD is ignored
      allb.delete();
      for (int k = 0; k < 6; k++) allb.push_back(8'($urandom));
      tx = allb[0:1];
      do_start(3, ts);
      send(0, 0, la);
      @(negedge clk);
      start = 1'b1; len = 1;
      @(negedge clk);
      start = 1'b0;
      tx = allb[2:5];
      send(1, 0, la);
      idle(3);
      tx = allb;
      build_expect(3);
      check_load("ign_start", 1, la);
      clear_log();

      // Randomized loads with random valid gaps
      for (int r = 0; r < 8; r++) begin
         l  = $urandom_range(1, 7);
         nb = ((l < DEPTH) ? l : DEPTH) * 2;
         tx.delete();
         for (int k = 0; k < nb; k++) tx.push_back(8'($urandom));
         do_start(3'(l), ts);
         send(2, 0, la);
         idle(3);
         build_expect(l);
         check_load("rand", 1, la);
         clear_log();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
